tpu_job_scheduler: RTL and testbench
====================================

TPU_JOB_SCHEDULER -- requirements
Module: tpu_job_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 2: job queue entries (power of two, 2..8).
REQ-002 SHALL have parameter TIMEOUT, default 4096: maximum RUN cycles before watchdog trip (16-bit).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 job_valid  in  1  job descriptor offered.
REQ-006 job_ready  out  1  queue can accept a descriptor.
REQ-007 job_kmn  in  24  [23:16]=K, [15:8]=M, [7:0]=N.
REQ-008 job_offset  in  32  input offset for the job.
REQ-009 tpu_in_valid  out  1  one-cycle launch pulse to the TPU.
REQ-010 tpu_K, tpu_M, tpu_N  out  8 each  dimensions driven to the TPU.
REQ-011 tpu_offset  out  32  offset driven to the TPU.
REQ-012 tpu_busy  in  1  TPU busy flag.
REQ-013 buf_owner  out  1  1 = TPU owns buffer ports A/B/C; 0 = CPU side.
REQ-014 done_valid  out  1  completion record available.
REQ-015 done_ready  in  1  completion consumer ready.
REQ-016 done_status  out  2  00 ok, 01 timeout, 10 zero-dim, 11 no-start.
REQ-017 pending  out  4  jobs queued (not yet launched).

Function
REQ-018 Job accepted on clk edge where job_valid && job_ready; job_ready = !full, independent of same-cycle pop.
REQ-019 Queue is FIFO, no bypass: a job accepted at edge t is visible at head from cycle t+1.
REQ-020 FSM states: IDLE, LAUNCH, WAIT_BUSY, RUN, REPORT.
REQ-021 IDLE with queue non-empty: pop head, latch K/M/N/offset into tpu_* registers; go LAUNCH, or REPORT with status 10 if any of K, M, N is zero.
REQ-022 LAUNCH: tpu_in_valid=1 for exactly this one cycle, buf_owner=1; go WAIT_BUSY.
REQ-023 WAIT_BUSY: tpu_busy=1 -> RUN; after 8 cycles without busy -> REPORT, status 11.
REQ-024 RUN: tpu_busy=0 -> REPORT, status 00.
REQ-025 buf_owner=1 exactly in LAUNCH, WAIT_BUSY, RUN; 0 otherwise.
REQ-026 tpu_K/M/N/offset held stable from LAUNCH until the next pop.
REQ-027 REPORT: done_valid=1, done_status stable until done_ready; on handshake go IDLE.
REQ-028 Jobs may be pushed in any state; pending updates the cycle after push/pop; simultaneous push and pop leaves pending unchanged.
REQ-029 With the queue full, job_valid is ignored; no descriptor is overwritten.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, flush queue, and clear every output and register to zero: job_ready=1 after release, tpu_in_valid=0, tpu_K/M/N=0, tpu_offset=0, buf_owner=0, done_valid=0, done_status=00, pending=0.
REQ-031 Reset mid-job SHALL drop the job silently; no completion record is produced.

Configuration
REQ-032 Macro TPU_SCHED_WATCHDOG_EN defined: a 16-bit counter cleared on entry to RUN increments each RUN cycle; on reaching TIMEOUT with tpu_busy still 1 -> REPORT, status 01, buf_owner released.
REQ-033 Macro undefined: no counter; RUN waits indefinitely; status 01 is never produced; TIMEOUT is unused.

Structure
REQ-034 Shared package tpu_sched_pkg SHALL hold the state enum, the status codes, the K/M/N field positions, and the WAIT_BUSY limit (8).
REQ-035 The job queue SHALL be a sub-module sched_job_fifo (width 56, depth DEPTH, full/empty/count outputs).

Verification
REQ-036 Single job K=4, M=4, N=4, offset=128 accepted at edge t -> tpu_in_valid high only at cycle t+2 with tpu_K=tpu_M=tpu_N=4 and tpu_offset=128; TPU busy for 20 cycles -> done_status=00; buf_owner high from t+2 until busy falls.
REQ-037 Push 3 jobs back-to-back with DEPTH=2 -> third job held (job_ready=0) until the first pop; pending sequence 1, 2, 1, 2; jobs launch in order.
REQ-038 Job with N=0 -> no tpu_in_valid, no buf_owner; done_status=10.
REQ-039 tpu_busy never rises after launch -> done_status=11 after 8 WAIT_BUSY cycles.
REQ-040 With TPU_SCHED_WATCHDOG_EN and TIMEOUT=16, busy held high -> done_status=01 after 16 RUN cycles; without the macro, no completion until busy falls.
REQ-041 Assert rst_n low during RUN with 1 job queued -> outputs zero immediately, pending=0; no done_valid after release.

Source files
------------

// File: rtl/tpu_sched_pkg.sv
// Shared types and constants for the TPU job scheduler: FSM states, completion
// status codes, K/M/N descriptor field positions and the launch-acknowledge limit.
package tpu_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_REPORT    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_TIMEOUT  = 2'b01,
    ST_ZERO_DIM = 2'b10,
    ST_NO_START = 2'b11
  } status_e;

  localparam int unsigned KMN_K_MSB = 23;
  localparam int unsigned KMN_K_LSB = 16;
  localparam int unsigned KMN_M_MSB = 15;
  localparam int unsigned KMN_M_LSB = 8;
  localparam int unsigned KMN_N_MSB = 7;
  localparam int unsigned KMN_N_LSB = 0;

  // Queue entry layout: {kmn[23:0], offset[31:0]}
  localparam int unsigned JOB_W = 56;

  localparam int unsigned WAIT_BUSY_LIMIT = 8;

  function automatic logic kmn_has_zero(input logic [23:0] kmn);
    return (kmn[KMN_K_MSB:KMN_K_LSB] == 8'd0) ||
           (kmn[KMN_M_MSB:KMN_M_LSB] == 8'd0) ||
           (kmn[KMN_N_MSB:KMN_N_LSB] == 8'd0);
  endfunction

endpackage

// File: rtl/sched_job_fifo.sv
// Job descriptor FIFO: power-of-two depth, no bypass, registered occupancy count.
module sched_job_fifo #(
  parameter int unsigned WIDTH = 56,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [3:0]       o_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [3:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == 4'(DEPTH));
  assign o_empty = (r_count == 4'd0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 4'd1;
      else if (w_pop && !w_push) r_count <= r_count - 4'd1;
    end
  end

endmodule

// File: rtl/tpu_job_scheduler.sv
// Queues K/M/N/offset job descriptors and sequences them one at a time onto the TPU,
// producing a completion status per job. Optional watchdog: TPU_SCHED_WATCHDOG_EN.
module tpu_job_scheduler
  import tpu_sched_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [23:0] job_kmn,
  input  logic [31:0] job_offset,
  output logic        tpu_in_valid,
  output logic [7:0]  tpu_K,
  output logic [7:0]  tpu_M,
  output logic [7:0]  tpu_N,
  output logic [31:0] tpu_offset,
  input  logic        tpu_busy,
  output logic        buf_owner,
  output logic        done_valid,
  input  logic        done_ready,
  output logic [1:0]  done_status,
  output logic [3:0]  pending
);

  localparam int unsigned WCW = $clog2(WAIT_BUSY_LIMIT);

  state_e           r_state;
  status_e          r_done_status;
  logic             r_tpu_in_valid;
  logic             r_buf_owner;
  logic             r_done_valid;
  logic [7:0]       r_tpu_k;
  logic [7:0]       r_tpu_m;
  logic [7:0]       r_tpu_n;
  logic [31:0]      r_tpu_offset;
  logic [WCW-1:0]   r_wait_cnt;
`ifdef TPU_SCHED_WATCHDOG_EN
  logic [15:0]      r_wd_cnt;
`else
  logic             w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
`endif

  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic [JOB_W-1:0] w_head;
  logic [23:0]      w_head_kmn;

  assign job_ready  = !w_full;
  assign w_pop      = (r_state == S_IDLE) && !w_empty;
  assign w_head_kmn = w_head[55:32];

  sched_job_fifo #(
    .WIDTH (JOB_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (job_valid),
    .i_wdata ({job_kmn, job_offset}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (pending)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_done_status  <= ST_OK;
      r_tpu_in_valid <= 1'b0;
      r_buf_owner    <= 1'b0;
      r_done_valid   <= 1'b0;
      r_tpu_k        <= '0;
      r_tpu_m        <= '0;
      r_tpu_n        <= '0;
      r_tpu_offset   <= '0;
      r_wait_cnt     <= '0;
`ifdef TPU_SCHED_WATCHDOG_EN
      r_wd_cnt       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_tpu_k      <= w_head_kmn[KMN_K_MSB:KMN_K_LSB];
            r_tpu_m      <= w_head_kmn[KMN_M_MSB:KMN_M_LSB];
            r_tpu_n      <= w_head_kmn[KMN_N_MSB:KMN_N_LSB];
            r_tpu_offset <= w_head[31:0];
            if (kmn_has_zero(w_head_kmn)) begin
              r_state       <= S_REPORT;
              r_done_valid  <= 1'b1;
              r_done_status <= ST_ZERO_DIM;
            end else begin
              r_state        <= S_LAUNCH;
              r_tpu_in_valid <= 1'b1;
              r_buf_owner    <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          r_tpu_in_valid <= 1'b0;
          r_wait_cnt     <= '0;
          r_state        <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (tpu_busy) begin
            r_state  <= S_RUN;
`ifdef TPU_SCHED_WATCHDOG_EN
            r_wd_cnt <= '0;
`endif
          end else if (r_wait_cnt == WCW'(WAIT_BUSY_LIMIT - 1)) begin
            r_state       <= S_REPORT;
            r_buf_owner   <= 1'b0;
            r_done_valid  <= 1'b1;
            r_done_status <= ST_NO_START;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!tpu_busy) begin
            r_state       <= S_REPORT;
            r_buf_owner   <= 1'b0;
            r_done_valid  <= 1'b1;
            r_done_status <= ST_OK;
          end
`ifdef TPU_SCHED_WATCHDOG_EN
          // The counter equals the number of RUN cycles already spent.
          else if (r_wd_cnt == 16'(TIMEOUT - 1)) begin
            r_state       <= S_REPORT;
            r_buf_owner   <= 1'b0;
            r_done_valid  <= 1'b1;
            r_done_status <= ST_TIMEOUT;
          end else begin
            r_wd_cnt <= r_wd_cnt + 16'd1;
          end
`endif
        end
        S_REPORT: begin
          if (done_ready) begin
            r_done_valid  <= 1'b0;
            r_done_status <= ST_OK;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tpu_in_valid = r_tpu_in_valid;
  assign tpu_K        = r_tpu_k;
  assign tpu_M        = r_tpu_m;
  assign tpu_N        = r_tpu_n;
  assign tpu_offset   = r_tpu_offset;
  assign buf_owner    = r_buf_owner;
  assign done_valid   = r_done_valid;
  assign done_status  = r_done_status;

endmodule

// File: tb/tb_tpu_job_scheduler.sv
// Self-checking bench for tpu_job_scheduler: descriptor/status scoreboard, table of
// single-job vectors, and hand sequences for latency, back-pressure, stall and reset.
module tb_tpu_job_scheduler;
  import tpu_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [23:0] job_kmn = '0;
  logic [31:0] job_offset = '0;
  logic        tpu_in_valid;
  logic [7:0]  tpu_K, tpu_M, tpu_N;
  logic [31:0] tpu_offset;
  logic        tpu_busy = 1'b0;
  logic        buf_owner;
  logic        done_valid;
  logic        done_ready = 1'b1;
  logic [1:0]  done_status;
  logic [3:0]  pending;

  tpu_job_scheduler #(.DEPTH(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_kmn(job_kmn), .job_offset(job_offset), .tpu_in_valid(tpu_in_valid),
    .tpu_K(tpu_K), .tpu_M(tpu_M), .tpu_N(tpu_N), .tpu_offset(tpu_offset),
    .tpu_busy(tpu_busy), .buf_owner(buf_owner), .done_valid(done_valid),
    .done_ready(done_ready), .done_status(done_status), .pending(pending)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [55:0] launch_q[$];
  int          busy_q[$];
  logic [1:0]  done_q[$];
  int          busy_rem = 0;
  int          owner_cycles = 0;
  int          valid_cycles = 0;
  int          done_seen = 0;
  logic        rec_on = 1'b0;
  logic [3:0]  last_pend = '0;
  logic [3:0]  pend_log[$];

  typedef struct {
    logic [23:0] kmn;
    logic [31:0] off;
    int          blen;
    logic [1:0]  st;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event, required none", name);
  endtask

  function automatic int exp_owner(input logic [1:0] st, input int blen);
    case (st)
      2'b10:   return 0;
      2'b11:   return 9;
      2'b01:   return 18;
      default: return blen + 1;
    endcase
  endfunction

  // Monitor, scoreboard and TPU model; all sampling on the falling edge.
  initial forever begin
    @(negedge clk);
    if (tpu_in_valid) begin
      valid_cycles++;
      if (launch_q.size() == 0) fail("unexpected_launch");
      else check("launch_desc", {tpu_K, tpu_M, tpu_N, tpu_offset}, launch_q.pop_front());
      check("owner_at_launch", buf_owner, 1);
      busy_rem = (busy_q.size() > 0) ? busy_q.pop_front() : 0;
    end
    if (done_valid && done_ready) begin
      done_seen++;
      if (done_q.size() == 0) fail("unexpected_done");
      else check("done_status", done_status, done_q.pop_front());
    end
    if (buf_owner) owner_cycles++;
    if (rec_on && pending != last_pend) begin
      pend_log.push_back(pending);
      last_pend = pending;
    end
    if (busy_rem > 0) begin
      tpu_busy = 1'b1;
      busy_rem--;
    end else begin
      tpu_busy = 1'b0;
    end
  end

  task automatic push_job(input logic [23:0] kmn, input logic [31:0] off, input int blen,
                          input logic [1:0] st, output int waited);
    logic rdy;
    waited = 0;
    if (st != ST_ZERO_DIM) begin
      launch_q.push_back({kmn, off});
      busy_q.push_back(blen);
    end
    done_q.push_back(st);
    job_valid  = 1'b1;
    job_kmn    = kmn;
    job_offset = off;
    forever begin
      rdy = job_ready;
      @(posedge clk); #1;
      if (rdy) break;
      waited++;
      if (waited > 300) begin
        fail("push_timeout");
        break;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int g = 0;
    while ((done_q.size() != 0 || pending != 0 || buf_owner || done_valid) && g < 400) begin
      @(posedge clk); #1;
      g++;
    end
    check(name, done_q.size(), 0);
  endtask

  initial begin
    int w;
    int lat;
    logic [15:0] packed_log;

    vecs[0] = '{24'h020305, 32'h0000_1000, 6, ST_OK};
    vecs[1] = '{24'h040400, 32'h0000_0200, 5, ST_ZERO_DIM};
    vecs[2] = '{24'h000101, 32'h0000_0300, 5, ST_ZERO_DIM};
    vecs[3] = '{24'h010001, 32'h0000_0400, 5, ST_ZERO_DIM};
    vecs[4] = '{24'h111111, 32'h0000_0040, 0, ST_NO_START};
    vecs[5] = '{24'hFF0107, 32'hDEAD_BEEF, 2, ST_OK};
    vecs[6] = '{24'h0A0B0C, 32'h1234_5678, 1, ST_NO_START};
`ifdef TPU_SCHED_WATCHDOG_EN
    vecs[7] = '{24'h080808, 32'h0000_0007, 40, ST_TIMEOUT};
`else
    vecs[7] = '{24'h080808, 32'h0000_0007, 40, ST_OK};
`endif

    repeat (2) @(posedge clk); #1;
    check("reset_ctrl", {tpu_in_valid, buf_owner, done_valid, done_status, pending}, 0);
    check("reset_data", {tpu_K, tpu_M, tpu_N, tpu_offset}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", job_ready, 1);
    check("pending_after_reset", pending, 0);

    // Single job: launch latency, one-cycle pulse, ownership window
    owner_cycles = 0;
    valid_cycles = 0;
    push_job(24'h040404, 32'd128, 20, ST_OK, w);
    job_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (tpu_in_valid) break;
    end
    wait_drain("single_drain");
    check("launch_latency", lat, 2);
    check("in_valid_cycles", valid_cycles, 1);
    check("single_owner_cycles", owner_cycles, 21);

    // Table of single-job vectors
    for (int i = 0; i < 8; i++) begin
      owner_cycles = 0;
      push_job(vecs[i].kmn, vecs[i].off, vecs[i].blen, vecs[i].st, w);
      job_valid = 1'b0;
      wait_drain("vec_drain");
      check("vec_owner_cycles", owner_cycles, exp_owner(vecs[i].st, vecs[i].blen));
    end

    // Back-pressure with DEPTH=2 while a long job occupies the TPU
    push_job(24'h010101, 32'h100, 12, ST_OK, w);
    job_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    last_pend = pending;
    pend_log.delete();
    rec_on = 1'b1;
    push_job(24'h020202, 32'h200, 3, ST_OK, w);
    push_job(24'h030303, 32'h300, 3, ST_OK, w);
    push_job(24'h040404, 32'h400, 3, ST_OK, w);
    job_valid = 1'b0;
    check("third_job_held", (w > 0), 1);
    @(negedge clk); #1;
    rec_on = 1'b0;
    packed_log = '0;
    foreach (pend_log[k]) packed_log = {packed_log[11:0], pend_log[k]};
    check("pending_seq", {pend_log.size(), packed_log}, {32'd4, 16'h1212});
    wait_drain("backpressure_drain");

    // REPORT held while consumer stalls; queue still accepts
    done_ready = 1'b0;
    push_job(24'h000505, 32'h0, 0, ST_ZERO_DIM, w);
    job_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    push_job(24'h030303, 32'h33, 4, ST_OK, w);
    job_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("stall_done_valid", done_valid, 1);
    check("stall_status", done_status, ST_ZERO_DIM);
    check("stall_pending", pending, 1);
    done_ready = 1'b1;
    wait_drain("stall_drain");

    // Reset in RUN with one job queued
    push_job(24'h050505, 32'h99, 1000, ST_OK, w);
    job_valid = 1'b0;
    repeat (6) @(posedge clk); #1;
    check("midjob_owner", buf_owner, 1);
    push_job(24'h060606, 32'h55, 3, ST_OK, w);
    job_valid = 1'b0;
    check("midjob_pending", pending, 1);
    rst_n = 1'b0;
    #1;
    check("midjob_reset_ctrl", {tpu_in_valid, buf_owner, done_valid, done_status, pending}, 0);
    check("midjob_reset_data", {tpu_K, tpu_M, tpu_N, tpu_offset}, 0);
    launch_q.delete();
    busy_q.delete();
    done_q.delete();
    busy_rem = 0;
    tpu_busy = 1'b0;
    done_seen = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk); #1;
    check("no_done_after_reset", done_seen, 0);
    check("pending_post_reset", pending, 0);
    check("ready_post_reset", job_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got simulation still running, required finish");
    $fatal(1);
  end

endmodule
